disp_argmin_sequencer: RTL and testbench



---
 rtl/disp_argmin_sequencer.sv | 129 ++++++++++++
 tb/tb_disp_argmin_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_argmin_sequencer.sv
// Serial winner-take-all over NUM_CANDIDATES costs per pixel, one cost per cycle.
// Emits the minimum cost and its disparity index over a valid/ready output.
module disp_argmin_sequencer #(
  parameter int VALUE_WIDTH    = 8,
  parameter int KEY_WIDTH      = 3,
  parameter int NUM_CANDIDATES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [VALUE_WIDTH-1:0] s_cost,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [VALUE_WIDTH-1:0] m_min_cost,
  output logic [KEY_WIDTH-1:0]   m_min_disp,
  output logic                   busy
);

  generate
    if (VALUE_WIDTH <= 0 || KEY_WIDTH <= 0 || NUM_CANDIDATES < 2 ||
        (2 ** KEY_WIDTH) < NUM_CANDIDATES) begin : g_bad_params
      $error("disp_argmin_sequencer: illegal parameter combination");
    end
  endgenerate

  localparam logic [KEY_WIDTH-1:0] LAST_IDX = KEY_WIDTH'(NUM_CANDIDATES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [KEY_WIDTH-1:0]   cand_cnt, cnt_next;
  logic [VALUE_WIDTH-1:0] run_cost, cost_next;
  logic [KEY_WIDTH-1:0]   run_disp, disp_next;
  logic [VALUE_WIDTH-1:0] out_cost_next;
  logic [KEY_WIDTH-1:0]   out_disp_next;
  logic                   accept;
  logic                   new_wins;
  logic [VALUE_WIDTH-1:0] win_cost;
  logic [KEY_WIDTH-1:0]   win_disp;

  // In HOLD a candidate may only enter in the cycle the result drains.
  assign s_ready = !clear && ((state == HOLD) ? m_ready : 1'b1);
  assign accept  = s_valid && s_ready;
  assign m_valid = (state == HOLD);
  assign busy    = (state == ACCUM);

  // Strict less-than: ties keep the earlier (lower) disparity.
  assign new_wins = (s_cost < run_cost);
  assign win_cost = new_wins ? s_cost : run_cost;
  assign win_disp = new_wins ? cand_cnt : run_disp;

  always_comb begin
    state_next    = state;
    cnt_next      = cand_cnt;
    cost_next     = run_cost;
    disp_next     = run_disp;
    out_cost_next = m_min_cost;
    out_disp_next = m_min_disp;
    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cost_next  = s_cost;
            disp_next  = '0;
            cnt_next   = KEY_WIDTH'(1);
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cost_next = win_cost;
            disp_next = win_disp;
            cnt_next  = cand_cnt + KEY_WIDTH'(1);
            if (cand_cnt == LAST_IDX) begin
              out_cost_next = win_cost;
              out_disp_next = win_disp;
              cnt_next      = '0;
              state_next    = HOLD;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            if (accept) begin
              cost_next  = s_cost;
              disp_next  = '0;
              cnt_next   = KEY_WIDTH'(1);
              state_next = ACCUM;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand_cnt   <= '0;
      run_cost   <= '0;
      run_disp   <= '0;
      m_min_cost <= '0;
      m_min_disp <= '0;
    end else begin
      state      <= state_next;
      cand_cnt   <= cnt_next;
      run_cost   <= cost_next;
      run_disp   <= disp_next;
      m_min_cost <= out_cost_next;
      m_min_disp <= out_disp_next;
    end
  end

endmodule

// File: tb/tb_disp_argmin_sequencer.sv
// Randomized and directed bench for disp_argmin_sequencer against a
// pixel-level argmin model built from queued candidate costs.
module tb_disp_argmin_sequencer;

  localparam int VW = 8;
  localparam int KW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          s_valid;
  logic          s_ready;
  logic [VW-1:0] s_cost;
  logic          m_valid;
  logic          m_ready;
  logic [VW-1:0] m_min_cost;
  logic [KW-1:0] m_min_disp;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: candidates of the open pixel plus at most one pending result.
  int pix_q[$];
  bit has_res   = 1'b0;
  int exp_cost  = 0;
  int exp_disp  = 0;
  int res_count = 0;

  disp_argmin_sequencer #(
    .VALUE_WIDTH(VW),
    .KEY_WIDTH(KW),
    .NUM_CANDIDATES(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_cost(s_cost),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_min_cost(m_min_cost),
    .m_min_disp(m_min_disp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    pix_q.delete();
    has_res = 1'b0;
  endtask

  // Checks the cycle's outputs at the falling edge, then advances the model
  // by what the coming rising edge should do.
  task automatic modelStep();
    bit exp_ready;
    int best;
    @(negedge clk);
    exp_ready = !clear && (!has_res || m_ready);
    checkOutput("s_ready", int'(s_ready), int'(exp_ready));
    checkOutput("m_valid", int'(m_valid), int'(has_res));
    checkOutput("busy", int'(busy), int'(pix_q.size() > 0));
    if (has_res) begin
      checkOutput("m_min_cost", int'(m_min_cost), exp_cost);
      checkOutput("m_min_disp", int'(m_min_disp), exp_disp);
    end
    if (clear) begin
      modelReset();
    end else begin
      if (has_res && m_ready) has_res = 1'b0;
      if (s_valid && exp_ready) begin
        pix_q.push_back(int'(s_cost));
        if (pix_q.size() == N) begin
          best = 0;
          for (int k = 1; k < N; k++)
            if (pix_q[k] < pix_q[best]) best = k;
          exp_cost = pix_q[best];
          exp_disp = best;
          has_res  = 1'b1;
          res_count++;
          pix_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sv, input int cost, input bit mr, input bit clr);
    s_valid = sv;
    s_cost  = VW'(cost);
    m_ready = mr;
    clear   = clr;
    modelStep();
  endtask

  task automatic runPixel(input int c0, input int c1, input int c2, input int c3,
                          input int c4, input int c5, input int c6, input int c7,
                          input bit mr);
    int c[N];
    c = '{c0, c1, c2, c3, c4, c5, c6, c7};
    for (int i = 0; i < N; i++) applyStimulus(1'b1, c[i], mr, 1'b0);
  endtask

  task automatic checkResult(input string tag, input int cost, input int disp);
    checkOutput({tag, "_valid"}, int'(m_valid), 1);
    checkOutput({tag, "_cost"}, int'(m_min_cost), cost);
    checkOutput({tag, "_disp"}, int'(m_min_disp), disp);
  endtask

  initial begin
    int start_count;
    int cycles;
    rst_n   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_cost  = '0;
    m_ready = 1'b0;
    #12;
    checkOutput("reset_m_valid", int'(m_valid), 0);
    checkOutput("reset_min_cost", int'(m_min_cost), 0);
    checkOutput("reset_min_disp", int'(m_min_disp), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_s_ready", int'(s_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed pixels");
    runPixel(9, 7, 12, 3, 5, 3, 8, 10, 1'b1);
    checkResult("tie_pixel", 3, 3);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("one_cycle_valid", int'(m_valid), 0);

    runPixel(255, 255, 255, 255, 255, 255, 255, 255, 1'b1);
    checkResult("all_max", 255, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    runPixel(8, 7, 6, 5, 4, 3, 2, 1, 1'b1);
    checkResult("descending", 1, 7);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    $display("[TB] back-to-back and backpressure");
    runPixel(4, 6, 2, 9, 9, 1, 5, 7, 1'b1);
    runPixel(3, 3, 3, 3, 3, 3, 3, 3, 1'b1);
    checkResult("stream_second", 3, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    runPixel(20, 10, 30, 40, 50, 60, 70, 80, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5, 1'b0, 1'b0);
    checkResult("held", 10, 1);
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    checkOutput("refill_busy", int'(busy), 1);
    for (int i = 1; i < N; i++) applyStimulus(1'b1, 6 + i, 1'b1, 1'b0);
    checkResult("refill", 5, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    $display("[TB] clear");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b1, 0, 1'b1, 1'b1);
    checkOutput("clear_busy", int'(busy), 0);
    runPixel(50, 40, 60, 45, 40, 70, 80, 90, 1'b1);
    checkResult("after_clear", 40, 1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    runPixel(1, 2, 3, 4, 5, 6, 7, 8, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("clear_hold_valid", int'(m_valid), 0);

    $display("[TB] async reset mid-pixel");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2, 1'b1, 1'b0);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_min_cost", int'(m_min_cost), 0);
    checkOutput("async_min_disp", int'(m_min_disp), 0);
    checkOutput("async_m_valid", int'(m_valid), 0);
    #1;
    rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    runPixel(8, 7, 6, 5, 4, 3, 2, 1, 1'b1);
    checkResult("post_reset", 1, 7);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    start_count = res_count;
    cycles = 0;
    while (res_count < start_count + 100 && cycles < 20000) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 9) < 7), 1'b0);
      cycles++;
    end
    checkOutput("random_pixels", res_count - start_count, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
